memory_responder: RTL
=====================

# memory_responder

Synthesizable multi-channel memory model that answers the memory controller's external valid/ready read and write protocol, i.e. it is the memory side of the `mem_read_*` / `mem_write_*` handshake. It holds a single-ported RAM array. It arbitrates round-robin among channels, one access per cycle, and returns each response after a fixed latency. It backs the data memory (8-bit words) or the program memory (16-bit words) in simulation and FPGA bring-up. A preload port lets the host initialise contents before `start`.

## Interface
- `ADDR_BITS`, 8, word address width; depth = 2^ADDR_BITS
- `DATA_BITS`, 8, word width (16 for program memory)
- `NUM_CHANNELS`, 4, independent requester channels
- `LATENCY`, 2, cycles from grant to ready; legal range 1–15
- Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock; all state changes on rising edge
- `reset`  in  1  synchronous, active-high
- `mem_read_valid`  in  NUM_CHANNELS  per-channel read request
- `mem_read_address`  in  NUM_CHANNELS*ADDR_BITS  channel c at [c*ADDR_BITS +: ADDR_BITS]
- `mem_read_ready`  out  NUM_CHANNELS  one-cycle read completion pulse
- `mem_read_data`  out  NUM_CHANNELS*DATA_BITS  read data, valid while ready is high
- `mem_write_valid`  in  NUM_CHANNELS  per-channel write request
- `mem_write_address`  in  NUM_CHANNELS*ADDR_BITS  write address
- `mem_write_data`  in  NUM_CHANNELS*DATA_BITS  write data
- `mem_write_ready`  out  NUM_CHANNELS  one-cycle write completion pulse
- `init_write_enable`  in  1  host preload strobe
- `init_address`  in  ADDR_BITS  preload address
- `init_data`  in  DATA_BITS  preload data

## Operation
- Per-channel FSM has three states:
  - IDLE: eligible for grant.
  - BUSY: counter runs LATENCY-1 down to 0.
  - RESPOND: ready high for exactly one cycle, then returns to IDLE.
- Request condition: a channel requests when it is IDLE and `mem_read_valid` or `mem_write_valid` is high.
  - If both are high on one channel, the write is served first. The read stays pending and becomes a new request once the channel is IDLE again.
- Arbiter: one grant per cycle. Search order is round-robin starting at `rr_ptr`. After a grant, `rr_ptr` becomes granted index + 1 mod NUM_CHANNELS. `rr_ptr` is unchanged when there is no grant.
- Access at the grant edge:
  - Write: RAM is updated at the grant edge.
  - Read: RAM is read at the grant edge, and the word is held in a per-channel data register until RESPOND.
- The channel records which kind of request was granted and pulses the matching ready output.
- Preload has priority over the arbiter. While `init_write_enable` is high:
  - RAM[init_address] <= init_data.
  - No channel is granted; busy channels keep counting.
- Address/data values are captured at grant. Later changes while BUSY are ignored.
- A channel in BUSY or RESPOND is not eligible. If valid is still high in the cycle after RESPOND, it is treated as a new request; the requester must drop valid after seeing ready.
- Requester deasserting valid while BUSY does not cancel the access; the ready pulse still occurs.
- Reset effects:
  - All channels go to IDLE, `rr_ptr` = 0, all ready outputs 0, all read data outputs 0.
  - RAM contents are not affected.
  - Reset mid-operation aborts pending responses; a write already performed at its grant edge persists.

## Timing
- A request is granted at edge E, when valid is high and the arbiter selects the channel.
- Ready is high during the cycle after edge E+LATENCY-1. That is LATENCY cycles after grant; LATENCY=1 gives ready in the cycle immediately after the grant edge.
- Minimum back-to-back on one channel: one request per LATENCY+1 cycles.
- Aggregate throughput: one access per cycle across channels.
- Same-cycle ordering: a write grant and a later read grant to the same address from different channels are ordered by grant. A read granted after the write's grant edge returns the new value.
- Ready and data outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - channel state encoding (IDLE/BUSY/RESPOND)
  - request-kind encoding (READ/WRITE)
  - the LATENCY range limits
- Natural sub-module: `rr_arbiter`, parameterised on NUM_CHANNELS. Inputs: request vector and pointer. Outputs: one-hot grant and grant index.
- RAM is an inferred array in the top module.

## Test plan
- Preload then single read:
  - Stimulus: init RAM[0x10]=0x5A. Channel 0 read 0x10, LATENCY=2.
  - Response: `mem_read_ready[0]` high exactly 2 cycles after grant with data 0x5A; one-cycle pulse.
- Write then read back:
  - Stimulus: channel 1 writes 0x33 to 0x20. After ready, it reads 0x20.
  - Response: write ready pulses once, then read returns 0x33.
- Four-channel contention:
  - Stimulus: all channels assert a read in the same cycle, `rr_ptr`=0.
  - Response: grants go to 0,1,2,3 on consecutive cycles, and ready pulses appear in that order.
- Fairness:
  - Stimulus: channel 0 re-requests immediately every time.
  - Response: channels 1–3 are each still granted within NUM_CHANNELS grant cycles.
- Read and write both high on one channel:
  - Stimulus: channel 2 raises read and write to 0x40 with write data 0x77.
  - Response: write ready first; the read, granted later, returns 0x77.
- Reset mid-operation:
  - Stimulus: reset while channel 3 is BUSY on a write to 0x08.
  - Response: no ready pulse appears; RAM[0x08] holds the written value; all outputs are 0 in the cycle after reset.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared encodings and limits for the multi-channel memory responder.
package memory_responder_pkg;

   typedef enum logic [1:0] {
      CH_IDLE    = 2'd0,
      CH_BUSY    = 2'd1,
      CH_RESPOND = 2'd2
   } ch_state_t;

   typedef enum logic {
      REQ_READ  = 1'b0,
      REQ_WRITE = 1'b1
   } req_kind_t;

   localparam int LATENCY_MIN = 1;
   localparam int LATENCY_MAX = 15;
   localparam int CNT_BITS    = 4;

endpackage

// File: rtl/memory_responder_rr_arbiter.sv
// Round-robin arbiter: first requester at or after pointer wins, one grant per cycle.
module rr_arbiter #(
   parameter  int NUM_CHANNELS = 4,
   localparam int IDX_BITS     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
   input  logic [NUM_CHANNELS-1:0] request,
   input  logic [IDX_BITS-1:0]     pointer,
   output logic [NUM_CHANNELS-1:0] grant,
   output logic [IDX_BITS-1:0]     grant_index,
   output logic                    grant_valid
);

   int idx;

   always_comb begin
      grant       = '0;
      grant_index = '0;
      grant_valid = 1'b0;
      idx         = 0;
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         idx = (int'(pointer) + i) % NUM_CHANNELS;
         if (!grant_valid && request[idx]) begin
            grant_valid = 1'b1;
            grant_index = IDX_BITS'(idx);
            grant[idx]  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/memory_responder.sv
// Memory side of the mem_read/mem_write valid/ready handshake: single-ported RAM,
// round-robin grant per cycle, fixed-latency one-cycle ready pulses, host preload.
//
// state      | meaning
// -----------+-----------------------------------------------
// CH_IDLE    | eligible for grant
// CH_BUSY    | access done at grant, counting down the latency
// CH_RESPOND | ready pulse for the recorded kind, one cycle
module memory_responder
   import memory_responder_pkg::*;
#(
   parameter int ADDR_BITS    = 8,
   parameter int DATA_BITS    = 8,
   parameter int NUM_CHANNELS = 4,
   parameter int LATENCY      = 2
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [NUM_CHANNELS-1:0]           mem_read_valid,
   input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_read_address,
   output logic [NUM_CHANNELS-1:0]           mem_read_ready,
   output logic [NUM_CHANNELS*DATA_BITS-1:0] mem_read_data,
   input  logic [NUM_CHANNELS-1:0]           mem_write_valid,
   input  logic [NUM_CHANNELS*ADDR_BITS-1:0] mem_write_address,
   input  logic [NUM_CHANNELS*DATA_BITS-1:0] mem_write_data,
   output logic [NUM_CHANNELS-1:0]           mem_write_ready,
   input  logic                              init_write_enable,
   input  logic [ADDR_BITS-1:0]              init_address,
   input  logic [DATA_BITS-1:0]              init_data
);

   localparam int IDX_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   // Out-of-range latencies clamp to what the counter can represent.
   localparam int LAT = (LATENCY < LATENCY_MIN) ? LATENCY_MIN :
                        (LATENCY > LATENCY_MAX) ? LATENCY_MAX : LATENCY;

   logic [DATA_BITS-1:0] ram [0:(1<<ADDR_BITS)-1];

   ch_state_t           state [NUM_CHANNELS];
   logic [CNT_BITS-1:0] count [NUM_CHANNELS];
   req_kind_t           kind  [NUM_CHANNELS];
   logic [IDX_BITS-1:0] rr_ptr;

   logic [NUM_CHANNELS-1:0] request;
   logic [NUM_CHANNELS-1:0] grant;
   logic [IDX_BITS-1:0]     grant_index;
   logic                    grant_valid;
   logic                    grant_write;
   logic [ADDR_BITS-1:0]    grant_read_address;
   logic [ADDR_BITS-1:0]    grant_write_address;
   logic [DATA_BITS-1:0]    grant_write_data;
   logic [DATA_BITS-1:0]    read_word;
   logic [IDX_BITS-1:0]     next_ptr;

   // Preload and reset both hold off the arbiter.
   always_comb begin
      request = '0;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
         request[c] = (state[c] == CH_IDLE) &&
                      (mem_read_valid[c] || mem_write_valid[c]) &&
                      !init_write_enable && !reset;
      end
   end

   rr_arbiter #(.NUM_CHANNELS(NUM_CHANNELS)) u_arbiter (
      .request     (request),
      .pointer     (rr_ptr),
      .grant       (grant),
      .grant_index (grant_index),
      .grant_valid (grant_valid)
   );

   always_comb begin
      grant_write         = grant_valid && mem_write_valid[grant_index];
      grant_read_address  = mem_read_address[int'(grant_index)*ADDR_BITS +: ADDR_BITS];
      grant_write_address = mem_write_address[int'(grant_index)*ADDR_BITS +: ADDR_BITS];
      grant_write_data    = mem_write_data[int'(grant_index)*DATA_BITS +: DATA_BITS];
      read_word           = ram[grant_read_address];
      next_ptr            = (int'(grant_index) == NUM_CHANNELS-1) ? '0 : grant_index + 1'b1;
   end

   // RAM contents survive reset.
   always_ff @(posedge clk) begin
      if (init_write_enable) begin
         ram[init_address] <= init_data;
      end else if (grant_write) begin
         ram[grant_write_address] <= grant_write_data;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rr_ptr          <= '0;
         mem_read_ready  <= '0;
         mem_write_ready <= '0;
         mem_read_data   <= '0;
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            state[c] <= CH_IDLE;
            count[c] <= '0;
            kind[c]  <= REQ_READ;
         end
      end else begin
         if (grant_valid) begin
            rr_ptr <= next_ptr;
         end
         for (int c = 0; c < NUM_CHANNELS; c++) begin
            mem_read_ready[c]  <= 1'b0;
            mem_write_ready[c] <= 1'b0;
            case (state[c])
               CH_IDLE: begin
                  if (grant[c]) begin
                     kind[c] <= grant_write ? REQ_WRITE : REQ_READ;
                     if (!grant_write) begin
                        mem_read_data[c*DATA_BITS +: DATA_BITS] <= read_word;
                     end
                     if (LAT == 1) begin
                        state[c]           <= CH_RESPOND;
                        mem_write_ready[c] <= grant_write;
                        mem_read_ready[c]  <= !grant_write;
                     end else begin
                        state[c] <= CH_BUSY;
                        count[c] <= CNT_BITS'(LAT - 1);
                     end
                  end
               end
               CH_BUSY: begin
                  count[c] <= count[c] - 1'b1;
                  if (count[c] == CNT_BITS'(1)) begin
                     state[c]           <= CH_RESPOND;
                     mem_write_ready[c] <= (kind[c] == REQ_WRITE);
                     mem_read_ready[c]  <= (kind[c] == REQ_READ);
                  end
               end
               CH_RESPOND: state[c] <= CH_IDLE;
               default:    state[c] <= CH_IDLE;
            endcase
         end
      end
   end

endmodule
